// File: rtl/sum_acc.sv
// sum_acc: accumulates N_SAMPLES consecutive unsigned samples into one widened
// total and presents it on a valid/ready output. A flush request closes a
// partial window early.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. A producer holds valid and its data
// stable until that transfer. The sink may change ready freely. On the input
// side in_ready follows out_ready combinationally while a total is being held.
module sum_acc #(
   parameter  int DATA_W    = 8,
   parameter  int N_SAMPLES = 4,
   localparam int CNT_W     = $clog2(N_SAMPLES + 1),
   localparam int ACC_W     = DATA_W + $clog2(N_SAMPLES)
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_data,
   output logic [CNT_W-1:0]  out_cnt,
   input  logic              out_ready,
   output logic              dbg_state
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LP_N    = CNT_W'(N_SAMPLES);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_SAMPLES - 1);

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACC_W-1:0]   r_out_data;
   logic [CNT_W-1:0]   r_out_cnt;

   state_t             w_state_nxt;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [ACC_W-1:0]   w_out_data_nxt;
   logic [CNT_W-1:0]   w_out_cnt_nxt;

   logic               w_in_ready;
   logic               w_accept;
   logic [ACC_W-1:0]   w_in_ext;
   logic [ACC_W-1:0]   w_sum;
   logic [CNT_W-1:0]   w_cnt_inc;

   // Input handshake; the sample is gated by accept so an unknown in_data
   // while in_valid is low never reaches the accumulator.
   assign w_in_ready = (r_state == ST_ACC) || out_ready;
   assign w_accept   = in_valid && w_in_ready;
   assign w_in_ext   = w_accept ? ACC_W'(in_data) : '0;
   assign w_sum      = r_acc + w_in_ext;
   assign w_cnt_inc  = r_cnt + CNT_W'(w_accept);

   // Next-state and datapath update for both FSM states.
   always_comb begin
      w_state_nxt    = r_state;
      w_acc_nxt      = r_acc;
      w_cnt_nxt      = r_cnt;
      w_out_data_nxt = r_out_data;
      w_out_cnt_nxt  = r_out_cnt;
      case (r_state)
         ST_ACC: begin
            if (w_accept && (r_cnt == LP_LAST)) begin
               // Full window; a coincident flush is absorbed into it.
               w_out_data_nxt = w_sum;
               w_out_cnt_nxt  = LP_N;
               w_acc_nxt      = '0;
               w_cnt_nxt      = '0;
               w_state_nxt    = ST_HOLD;
            end else if (flush && (w_cnt_inc != '0)) begin
               // Early close of a non-empty partial window.
               w_out_data_nxt = w_sum;
               w_out_cnt_nxt  = w_cnt_inc;
               w_acc_nxt      = '0;
               w_cnt_nxt      = '0;
               w_state_nxt    = ST_HOLD;
            end else if (w_accept) begin
               w_acc_nxt = w_sum;
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_HOLD: begin
            // Flush is ignored here; accept implies out_ready, so an accepted
            // sample always starts the next window as the total leaves.
            if (out_ready) begin
               w_state_nxt = ST_ACC;
               if (w_accept) begin
                  w_acc_nxt = w_in_ext;
                  w_cnt_nxt = CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_ACC;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= ST_ACC;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_out_data <= '0;
         r_out_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_acc      <= w_acc_nxt;
         r_cnt      <= w_cnt_nxt;
         r_out_data <= w_out_data_nxt;
         r_out_cnt  <= w_out_cnt_nxt;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == ST_HOLD);
   assign out_data  = r_out_data;
   assign out_cnt   = r_out_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_sum_acc.sv
// Bench for sum_acc: directed scenarios plus a randomized run, all watched by
// a window-level reference model with an expected-output queue.
module tb_sum_acc;

   localparam int DATA_W = 8;
   localparam int N      = 4;
   localparam int CNT_W  = $clog2(N + 1);
   localparam int ACC_W  = DATA_W + $clog2(N);
   localparam int EW     = CNT_W + ACC_W;

   logic              clk;
   logic              aresetn;
   logic              drv_valid;
   logic [DATA_W-1:0] drv_data;
   logic              flush;
   logic              out_ready;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [ACC_W-1:0]  out_data;
   logic [CNT_W-1:0]  out_cnt;
   logic              dbg_state;

   // upstream registered adder (c <= a + b) for the end-to-end case
   logic              use_adder;
   logic [DATA_W-1:0] add_a, add_b, add_c;
   logic              add_en, add_cv;

   int errors;
   int checks;
   logic [EW-1:0] exp_q[$];
   int m_sum;
   int m_cnt;

   sum_acc #(.DATA_W(DATA_W), .N_SAMPLES(N)) dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_cnt   (out_cnt),
      .out_ready (out_ready),
      .dbg_state (dbg_state)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      add_c  <= add_a + add_b;
      add_cv <= add_en;
   end

   assign in_valid = use_adder ? add_cv : drv_valid;
   assign in_data  = use_adder ? add_c  : drv_data;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d);
      drv_valid = 1'b1;
      drv_data  = DATA_W'(d);
      tick();
   endtask

   task automatic window4(input int a, input int b, input int c, input int d);
      send(a);
      send(b);
      send(c);
      send(d);
      drv_valid = 1'b0;
   endtask

   // scoreboard: window-level model, evaluated mid-cycle for the next edge
   task automatic monitor();
      bit pend, exp_rdy;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL mon_reset_valid: got %b want 0", out_valid);
            end
         end else begin
            pend    = (exp_q.size() != 0);
            exp_rdy = !pend || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
               errors++;
               $display("FAIL mon_in_ready t=%0t: got %b want %b (state=%b)", $time, in_ready, exp_rdy, dbg_state);
            end
            checks++;
            if (out_valid !== pend) begin
               errors++;
               $display("FAIL mon_out_valid t=%0t: got %b want %b (state=%b)", $time, out_valid, pend, dbg_state);
            end
            if (pend) begin
               checks++;
               if ({out_cnt, out_data} !== exp_q[0]) begin
                  errors++;
                  $display("FAIL mon_out t=%0t: got cnt=%0d data=%0d want cnt=%0d data=%0d",
                           $time, out_cnt, out_data, exp_q[0][EW-1:ACC_W], exp_q[0][ACC_W-1:0]);
               end
            end
            if (pend && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy) begin
               m_sum += int'(in_data);
               m_cnt++;
            end
            if (!pend && (m_cnt == N || (flush && m_cnt > 0))) begin
               exp_q.push_back({CNT_W'(m_cnt), ACC_W'(m_sum)});
               m_sum = 0;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b d=%0d c=%0d want 0 0 0", out_valid, out_data, out_cnt);
      end
      #10 aresetn = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      window4(1, 3, 5, 7);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(16) || out_cnt !== CNT_W'(4)) begin
         errors++;
         $display("FAIL basic_window: got v=%b d=%0d c=%0d want 1 16 4", out_valid, out_data, out_cnt);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulse: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_max();
      window4(255, 255, 255, 255);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(1020) || out_cnt !== CNT_W'(4)) begin
         errors++;
         $display("FAIL max_window: got v=%b d=%0d c=%0d want 1 1020 4", out_valid, out_data, out_cnt);
      end
      tick();
      window4(0, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(0) || out_cnt !== CNT_W'(4)) begin
         errors++;
         $display("FAIL zero_window: got v=%b d=%0d c=%0d want 1 0 4", out_valid, out_data, out_cnt);
      end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      window4(9, 11, 13, 15);
      drv_valid = 1'b1;
      drv_data  = DATA_W'(2);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== ACC_W'(48) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b d=%0d rdy=%b want 1 48 0", k, out_valid, out_data, in_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 1", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_emitted: got v=%b want 0", out_valid);
      end
      send(4);
      send(6);
      send(8);
      drv_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(20) || out_cnt !== CNT_W'(4)) begin
         errors++;
         $display("FAIL bp_next_window: got v=%b d=%0d c=%0d want 1 20 4", out_valid, out_data, out_cnt);
      end
      tick();
   endtask

   task automatic test_flush();
      send(9);
      send(11);
      drv_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(20) || out_cnt !== CNT_W'(2)) begin
         errors++;
         $display("FAIL flush_partial: got v=%b d=%0d c=%0d want 1 20 2", out_valid, out_data, out_cnt);
      end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty: got v=%b want 0", out_valid);
      end
      send(1);
      send(3);
      flush = 1'b1;
      send(5);
      drv_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(9) || out_cnt !== CNT_W'(3)) begin
         errors++;
         $display("FAIL flush_with_sample: got v=%b d=%0d c=%0d want 1 9 3", out_valid, out_data, out_cnt);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      send(1);
      send(3);
      send(5);
      drv_valid = 1'b0;
      #1 aresetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0) begin
         errors++;
         $display("FAIL reset_mid_async: got v=%b d=%0d c=%0d want 0 0 0", out_valid, out_data, out_cnt);
      end
      @(negedge clk);
      #2 aresetn = 1'b1;
      tick();
      window4(2, 2, 2, 2);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(8) || out_cnt !== CNT_W'(4)) begin
         errors++;
         $display("FAIL reset_mid_next: got v=%b d=%0d c=%0d want 1 8 4", out_valid, out_data, out_cnt);
      end
      tick();
   endtask

   task automatic test_end_to_end();
      int got_q[$];
      use_adder = 1'b1;
      for (int i = 0; i < 8; i++) begin
         add_a  = DATA_W'(i);
         add_b  = DATA_W'(i + 1);
         add_en = 1'b1;
         tick();
         if (out_valid) got_q.push_back(int'(out_data));
      end
      add_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid) got_q.push_back(int'(out_data));
      end
      use_adder = 1'b0;
      checks++;
      if (got_q.size() != 2) begin
         errors++;
         $display("FAIL e2e_count: got %0d windows want 2", got_q.size());
      end else begin
         checks++;
         if (got_q[0] != 16 || got_q[1] != 48) begin
            errors++;
            $display("FAIL e2e_totals: got %0d,%0d want 16,48", got_q[0], got_q[1]);
         end
      end
   endtask

   task automatic test_random();
      bit stall;
      stall = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!stall) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_data  = DATA_W'($urandom_range(0, 255));
         end
         flush     = ($urandom_range(0, 11) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         stall = drv_valid && !in_ready;
         tick();
      end
      drv_valid = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain: %0d expected windows never emitted", exp_q.size());
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      m_sum     = 0;
      m_cnt     = 0;
      aresetn   = 1'b0;
      drv_valid = 1'b0;
      drv_data  = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      use_adder = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_en    = 1'b0;
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_end_to_end();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sum_acc.md
Name: sum_acc

Overview:
Downstream consumer of the registered 8-bit adder stream (`sum`, output `c`). It accumulates N_SAMPLES consecutive sum results into one widened total and presents that total on a valid/ready output with backpressure. A flush request closes a partial window early. It sits between the adder and the result sink or scoreboard.

Parameters:
DATA_W, 8, width of incoming sum samples.
N_SAMPLES, 4, samples per window; legal values are 2 and above.
CNT_W (local), $clog2(N_SAMPLES+1), width of the sample counter and of out_cnt.
ACC_W (local), DATA_W+$clog2(N_SAMPLES), accumulator width; it is sized so the sum can never wrap.

Ports:
clk  input  1  clock, rising edge.
aresetn  input  1  asynchronous reset, active-low.
in_valid  input  1  in_data carries a sample.
in_data  input  DATA_W  sample, unsigned; normally driven from the adder's `c`.
in_ready  output  1  block accepts a sample this cycle.
flush  input  1  single-cycle request to close the current partial window.
out_valid  output  1  out_data and out_cnt are valid.
out_data  output  ACC_W  window total, unsigned.
out_cnt  output  CNT_W  number of samples in the emitted window.
out_ready  input  1  sink accepts the output this cycle.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - state=ACC, acc=0, cnt=0.
  - out_valid=0, out_data=0, out_cnt=0.
  - Reset mid-window discards any partial sum; nothing is emitted for it.
- Accept: a sample is taken when in_valid && in_ready at posedge.
- Emit: an output is taken when out_valid && out_ready at posedge.
- FSM state ACC:
  - in_ready=1, out_valid=0.
  - On accept with cnt < N_SAMPLES-1: acc += in_data, cnt += 1.
  - On accept with cnt == N_SAMPLES-1: out_data = acc+in_data, out_cnt = N_SAMPLES, clear acc and cnt, go to HOLD.
- Latency: out_valid rises on the cycle after the N-th accept.
- FSM state HOLD:
  - out_valid=1; out_data and out_cnt stay stable until emitted.
  - in_ready = out_ready (combinational path, same cycle). No sample is lost; the upstream holds in_valid/in_data while in_ready=0.
  - Emit without accept: go to ACC.
  - Emit with accept in the same cycle: the sample becomes the first of the next window (acc=in_data, cnt=1), go to ACC.
  - With N_SAMPLES=2 this back-to-back case still needs two samples per window.
- Flush (sampled only in ACC):
  - Treat "cnt+accept" as cnt plus 1 if a sample is accepted in the same cycle, else cnt.
  - If cnt+accept > 0: emit acc (+in_data if accepted) with out_cnt = cnt+accept, go to HOLD.
  - If cnt+accept == 0: ignored.
  - Flush coinciding with the N-th accept produces a single window with out_cnt=N_SAMPLES.
  - Flush in HOLD is ignored and not remembered.
- Width rules: all arithmetic is unsigned; in_data is zero-extended to ACC_W. Maximum out_data is N_SAMPLES*(2^DATA_W-1), which is 1020 at the defaults.
- in_data is ignored when in_valid=0. X on in_data while in_valid=0 must not propagate into acc.
- No dropped or duplicated samples under any out_ready pattern.

Test Plan:
- Defaults, reset released, in_valid continuous with samples 1,3,5,7, out_ready=1 → out_valid=1 one cycle after the 4th accept, out_data=16, out_cnt=4, out_valid pulses for one cycle.
- Samples 255,255,255,255 → out_data=1020, out_cnt=4, no wrap. Then samples 0,0,0,0 → out_data=0.
- Backpressure: window 9,11,13,15 with out_ready=0 for 3 cycles after out_valid rises → out_valid stays 1 and out_data stays 48 throughout, in_ready=0, upstream sample 2 held. When out_ready rises, 48 is emitted and 2 is accepted in the same cycle. The next window 2,4,6,8 → out_data=20, out_cnt=4.
- Flush: samples 9,11 then flush with in_valid=0 → out_data=20, out_cnt=2. Flush with cnt=0 and in_valid=0 → no output. Flush together with the 3rd sample 5 after 1,3 → out_data=9, out_cnt=3.
- Reset mid-window: samples 1,3,5 accepted, then aresetn=0 for one cycle (asynchronous, between edges) → out_valid=0 immediately. After release, samples 2,2,2,2 → out_data=8, out_cnt=4.
- End-to-end: upstream `sum` driven with a=i, b=i+1 for i=0..7, producing c=1,3,…,15, connected to in_data with in_valid aligned to c → two windows, out_data=16 then 48.
